bp_me_stream_lock_arbiter: RTL
==============================

Name: bp_me_stream_lock_arbiter

Overview:
- Shares one BedRock Stream output channel among num_inputs_p BedRock Stream requesters, for example several LCE/cache stream sources feeding a single stream-to-burst converter.
- Arbitration is round-robin at message granularity. The grant locks from the first accepted beat until the beat carrying last is accepted, so multi-beat messages are never interleaved.
- Datapath is a zero-latency combinational mux; only grant/lock/priority state is registered.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config supplying paddr_width_p, lce_id_width_p, lce_assoc_p.
- num_inputs_p, 2, number of requesting stream channels (>=2).
- data_width_p, 64, stream beat data width, identical on all inputs and the output.
- payload_width_p, "inv", BedRock header payload width.
- msg_header_width_lp, derived, BedRock msg header width from paddr_width_p, payload_width_p, data_width_p, lce_id_width_p, lce_assoc_p.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- in_msg_header_i  in  num_inputs_p*msg_header_width_lp  per-input headers, input i at slice i.
- in_msg_data_i  in  num_inputs_p*data_width_p  per-input beat data.
- in_msg_v_i  in  num_inputs_p  per-input valid.
- in_msg_last_i  in  num_inputs_p  per-input last-beat flag.
- in_msg_ready_and_o  out  num_inputs_p  per-input ready (ready-valid-and).
- out_msg_header_o  out  msg_header_width_lp  header of the granted input.
- out_msg_data_o  out  data_width_p  data of the granted input.
- out_msg_v_o  out  1  output valid.
- out_msg_last_o  out  1  last flag of the granted input.
- out_msg_ready_and_i  in  1  downstream ready (ready-valid-and).

Behaviour:
- Interface: one clock clk_i; reset_i is synchronous and active-high. All channels use ready-valid-and; a beat transfers when v & ready_and are both high in the same cycle.
- Registered state:
  - lock_r (1b) and lock_id_r (log2 num_inputs_p).
  - hold_r and hold_id_r, which hold a presented but unaccepted grant.
  - prio_r, the round-robin highest-priority index.
- Reset values: lock_r=0, hold_r=0, prio_r=0. During and right after reset, out_msg_v_o=0 and all in_msg_ready_and_o=0 while reset_i is high.
- Grant selection each cycle, in order:
  1. If lock_r, use lock_id_r.
  2. Else if hold_r, use hold_id_r.
  3. Else pick the first valid input scanning prio_r, prio_r+1, ... modulo num_inputs_p (wrap-around).
- Outputs:
  - out_msg_v_o = in_msg_v_i[grant]; 0 if no grant.
  - header, data and last are muxed from the grant index.
  - in_msg_ready_and_o[grant] = out_msg_ready_and_i; all other readies are 0.
  - Readies must not depend combinationally on non-granted valids beyond the selection logic.
- Hold:
  - Set when out_msg_v_o & ~out_msg_ready_and_i & ~lock_r, capturing the grant.
  - Cleared on the next handshake.
  - Guarantees the presented beat never switches source before acceptance, even if a higher-priority input raises valid.
- Lock:
  - Set on a handshake with ~out_msg_last_o, capturing the grant.
  - Cleared on a handshake with out_msg_last_o.
  - A single-beat message (last on the first beat) never sets lock.
- Priority update: on any handshake with last=1, prio_r <= (grant+1) mod num_inputs_p, with wrap from num_inputs_p-1 to 0. prio_r is otherwise unchanged.
- Locked source drops valid mid-message: the output idles with out_msg_v_o=0. Lock is held and no other input is granted (no bubbles filled by others).
- Simultaneous events: lock-clear and a new message on the same cycle are not possible. A new grant is evaluated the cycle after the last-beat handshake, giving 1-cycle arbitration per message boundary with zero bubble on the datapath.
- Reset mid-message: all state clears immediately. The partially sent message is abandoned, and the upstream source is responsible for restarting.
- Non-power-of-two num_inputs_p: wrap uses explicit compare, not bit truncation.
- Assertions (simulation only):
  - no more than one in_msg_ready_and_o bit high;
  - a locked grant never changes before last is accepted.

Test Plan:
- num_inputs_p=2, both inputs present single-beat messages continuously, ready=1 → grants alternate 0,1,0,1; prio_r toggles every cycle.
- Input0 sends a 4-beat message (last on beat 4) while input1 valid throughout → out shows 4 beats from input0 back-to-back, then input1; in_msg_ready_and_o[1]=0 for those 4 cycles.
- Input1 valid alone, out_msg_ready_and_i=0 for 3 cycles, input0 raises valid in cycle 2 with prio_r=0 → output stays on input1 (hold) until accepted, then input0 is granted.
- Input0 locked after beat 1 of 2, drops valid for 2 cycles while input1 valid → out_msg_v_o=0 for 2 cycles; beat 2 of input0 then completes before input1 is granted.
- num_inputs_p=3, prio_r=2, inputs 0 and 1 valid → input0 wins (wrap), after which prio_r=1.
- reset_i asserted after beat 2 of a 4-beat locked message → next cycle lock_r=0, prio_r=0, out_msg_v_o=0; after release, input0 is granted first.

Source files
------------

// File: rtl/bp_me_stream_lock_arbiter_if.sv
// Bundle of n_p BedRock stream channels (header/data/valid/last forward, ready-and back).
// A master drives the beat and a slave returns ready_and. n_p=1 gives a plain single channel.
interface bp_me_stream_lock_arbiter_if #(
   parameter int n_p            = 1,
   parameter int header_width_p = 66,
   parameter int data_width_p   = 64
);
   logic [n_p*header_width_p-1:0] header;
   logic [n_p*data_width_p-1:0]   data;
   logic [n_p-1:0]                v;
   logic [n_p-1:0]                last;
   logic [n_p-1:0]                ready_and;

   modport master (output header, data, v, last, input ready_and);
   modport slave  (input header, data, v, last, output ready_and);
endinterface

// File: rtl/bp_me_stream_lock_arbiter.sv
// Round-robin N:1 BedRock stream arbiter, locked per message; zero-latency mux, state-only regs.
// Backpressure: downstream ready_and is steered to the granted input only; the grant holds until accepted.
module bp_me_stream_lock_arbiter #(
   parameter int paddr_width_p    = 40,
   parameter int lce_id_width_p   = 4,
   parameter int lce_assoc_p      = 8,
   parameter int num_inputs_p     = 2,
   parameter int data_width_p     = 64,
   parameter int payload_width_p  = 2*lce_id_width_p + $clog2(lce_assoc_p) + 4,
   localparam int msg_header_width_lp = 8 + paddr_width_p + 3 + payload_width_p,
   localparam int sel_w_lp            = $clog2(num_inputs_p)
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   bp_me_stream_lock_arbiter_if.slave  in_msg,
   bp_me_stream_lock_arbiter_if.master out_msg
);

   logic                lock_r;
   logic [sel_w_lp-1:0] lock_id_r;
   logic                hold_r;
   logic [sel_w_lp-1:0] hold_id_r;
   logic [sel_w_lp-1:0] prio_r;

   logic                pick_v;
   logic [sel_w_lp-1:0] pick_id;
   logic                grant_v;
   logic [sel_w_lp-1:0] grant_id;
   logic                hs;
   int                  scan;

   // Scan from highest offset down so the input closest to prio_r wins.
   always_comb begin
      pick_v  = 1'b0;
      pick_id = '0;
      scan    = 0;
      for (int i = num_inputs_p-1; i >= 0; i--) begin
         scan = int'(prio_r) + i;
         if (scan >= num_inputs_p) scan = scan - num_inputs_p;
         if (in_msg.v[scan]) begin
            pick_v  = 1'b1;
            pick_id = sel_w_lp'(scan);
         end
      end
   end

   always_comb begin
      grant_v  = 1'b1;
      grant_id = pick_id;
      if (lock_r)      grant_id = lock_id_r;
      else if (hold_r) grant_id = hold_id_r;
      else             grant_v  = pick_v;
   end

   assign out_msg.header = in_msg.header[grant_id*msg_header_width_lp +: msg_header_width_lp];
   assign out_msg.data   = in_msg.data[grant_id*data_width_p +: data_width_p];
   assign out_msg.last   = in_msg.last[grant_id];
   assign out_msg.v      = grant_v & in_msg.v[grant_id] & ~reset_i;

   always_comb begin
      in_msg.ready_and           = '0;
      in_msg.ready_and[grant_id] = grant_v & out_msg.ready_and[0] & ~reset_i;
   end

   assign hs = out_msg.v[0] & out_msg.ready_and[0];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lock_r    <= 1'b0;
         lock_id_r <= '0;
         hold_r    <= 1'b0;
         hold_id_r <= '0;
         prio_r    <= '0;
      end else begin
         if (hs) begin
            hold_r <= 1'b0;
         end else if (out_msg.v[0] && !lock_r) begin
            hold_r    <= 1'b1;
            hold_id_r <= grant_id;
         end

         if (hs && !out_msg.last[0]) begin
            lock_r    <= 1'b1;
            lock_id_r <= grant_id;
         end else if (hs) begin
            lock_r <= 1'b0;
            prio_r <= (int'(grant_id) == num_inputs_p-1) ? '0 : grant_id + 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!reset_i) begin
         assert ($onehot0(in_msg.ready_and))
            else $error("arbiter: more than one ready_and high");
         if (lock_r)
            assert ((in_msg.ready_and & ~(num_inputs_p'(1) << lock_id_r)) == '0)
               else $error("arbiter: locked grant moved before last");
      end
   end
`endif

endmodule
